// File: rtl/dcp_uart_arbiter.sv
// dcp_uart_arbiter: independent round-robin TX/RX arbiters sharing one UART among N_REQ handlers.
// Optional per-grant watchdog with sticky arb_err when DCP_ARB_TIMEOUT_EN is defined.
module dcp_uart_arb_rr #(
    parameter int N_REQ = 4
`ifdef DCP_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [N_REQ-1:0] gnt,
    output logic             err
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_DROP} state_t;
    state_t state;
    logic [PW-1:0] ptr, gidx, pick, nxt;
    logic drop, expire;

    // Scan downward so the requester closest to ptr (cyclically) wins.
    always_comb begin
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N_REQ]) pick = PW'((int'(ptr) + i) % N_REQ);
    end

    assign nxt  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    assign drop = (state != IDLE) && !ack && !req[gidx];

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            gidx  <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= GRANT;
                gnt   <= N_REQ'(1) << pick;
                gidx  <= pick;
            end
        end else if (drop || expire) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= nxt;
        end else if (ack) begin
            state <= WAIT_DROP;
        end

`ifdef DCP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign expire = (state != IDLE) && (cnt == CW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == IDLE || expire) ? '0 : cnt + 1'b1;
            if (expire) err <= 1'b1;
        end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif
endmodule

module dcp_uart_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 32
`ifdef DCP_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req_tx_i,
    input  logic [N_REQ-1:0]    type_tx_i,
    input  logic [N_REQ*DW-1:0] dout_i,
    output logic [N_REQ-1:0]    ack_tx_o,
    input  logic [N_REQ-1:0]    req_rx_i,
    input  logic [N_REQ-1:0]    type_rx_i,
    output logic [N_REQ-1:0]    ack_rx_o,
    output logic [DW-1:0]       din_rx_o,
    output logic                flag_rx_o,
    output logic                req_tx,
    output logic                type_tx,
    output logic [DW-1:0]       dout_tx,
    input  logic                ack_tx,
    output logic                req_rx,
    output logic                type_rx,
    input  logic                ack_rx,
    input  logic [DW-1:0]       din_rx,
    input  logic                flag_rx,
    output logic [N_REQ-1:0]    gnt_tx,
    output logic [N_REQ-1:0]    gnt_rx,
    output logic                arb_err
);
    logic err_tx, err_rx;

    dcp_uart_arb_rr #(
        .N_REQ(N_REQ)
`ifdef DCP_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_tx (.clk(clk), .rstn(rstn), .req(req_tx_i), .ack(ack_tx), .gnt(gnt_tx), .err(err_tx));

    dcp_uart_arb_rr #(
        .N_REQ(N_REQ)
`ifdef DCP_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_rx (.clk(clk), .rstn(rstn), .req(req_rx_i), .ack(ack_rx), .gnt(gnt_rx), .err(err_rx));

    assign req_tx    = |(req_tx_i & gnt_tx);
    assign type_tx   = |(type_tx_i & gnt_tx);
    assign ack_tx_o  = gnt_tx & {N_REQ{ack_tx}};
    assign req_rx    = |(req_rx_i & gnt_rx);
    assign type_rx   = |(type_rx_i & gnt_rx);
    assign ack_rx_o  = gnt_rx & {N_REQ{ack_rx}};
    assign din_rx_o  = din_rx;
    assign flag_rx_o = flag_rx;
    assign arb_err   = err_tx | err_rx;

    always_comb begin
        dout_tx = '0;
        for (int k = 0; k < N_REQ; k++)
            if (gnt_tx[k]) dout_tx = dout_tx | dout_i[k*DW +: DW];
    end
endmodule
